apb_slot_ctrl: RTL and testbench
================================

APB_SLOT_CTRL -- requirements
Module: apb_slot_ctrl

Interface
REQ-001 Parameter SLOT_LSB, default 8: LSB of the 2-bit slot field MSSPADDR[SLOT_LSB+1:SLOT_LSB].
REQ-002 Parameter TO_CYCLES, default 16, legal 2..255: ACCESS-phase cycles allowed before timeout.
REQ-003 FAB_CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 M2F_RESET_N  in  1  asynchronous, active-low reset.
REQ-005 MSSPSEL, MSSPENABLE, MSSPWRITE  in  1 each  APB3 master control from MSS.
REQ-006 MSSPADDR  in  20  master address; MSSPWDATA  in  32  master write data.
REQ-007 MSSPRDATA  out  32; MSSPREADY  out  1; MSSPSLVERR  out  1  responses to master.
REQ-008 SLOT_EN  in  4  per-slot enable, quasi-static.
REQ-009 S_PSEL  out  4  one-hot slave select; S_PENABLE, S_PWRITE  out  1; S_PADDR  out  SLOT_LSB  low address bits; S_PWDATA  out  32.
REQ-010 S_PRDATA  in  128  slot n at bits [32n+31:32n]; S_PREADY  in  4; S_PSLVERR  in  4.
REQ-011 TIMEOUT_CLR  in  1  clears sticky timeout status; TIMEOUT_IRQ  out  1  sticky flag; LAST_TO_SLOT  out  2  slot of most recent timeout.

Function
REQ-012 FSM states IDLE, SETUP, ACCESS, ERR; S_PENABLE/S_PWRITE/S_PADDR/S_PWDATA combinational pass-through of the master bus.
REQ-013 IDLE->SETUP when MSSPSEL=1 and MSSPENABLE=0; SETUP->ACCESS when MSSPENABLE=1; MSSPENABLE=1 seen in IDLE is ignored (stays IDLE, no response).
REQ-014 S_PSEL[slot]=MSSPSEL while state is not ERR and SLOT_EN[slot]=1; all other S_PSEL bits 0; zero-cycle decode latency.
REQ-015 Enabled slot in ACCESS: MSSPREADY, MSSPSLVERR, MSSPRDATA combinationally muxed from the selected slot; ACCESS->IDLE when S_PREADY[slot]=1.
REQ-016 Disabled slot: S_PSEL stays 0; first ACCESS cycle drives MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0; ACCESS->IDLE.
REQ-017 8-bit wait counter cleared on SETUP entry, increments each ACCESS cycle without S_PREADY[slot].
REQ-018 When counter = TO_CYCLES-1 and S_PREADY[slot]=0, ACCESS->ERR; ERR lasts one cycle driving S_PSEL=0, MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0, then ERR->IDLE.
REQ-019 ERR entry sets TIMEOUT_IRQ=1 and loads LAST_TO_SLOT with the slot; set wins over simultaneous TIMEOUT_CLR.
REQ-020 TIMEOUT_CLR=1 with no timeout event clears TIMEOUT_IRQ next edge; LAST_TO_SLOT holds.
REQ-021 S_PREADY[slot]=1 on the threshold cycle completes normally (slave wins), no timeout.
REQ-022 Late S_PREADY from a timed-out slave is ignored; unselected slots' S_PREADY/S_PSLVERR never affect the master.
REQ-023 Outside ACCESS/ERR: MSSPREADY=0, MSSPSLVERR=0, MSSPRDATA=0.
REQ-024 Back-to-back: a new setup phase in the cycle after completion is decoded from IDLE without a dead cycle.

Reset
REQ-025 M2F_RESET_N=0 forces immediately: state IDLE, counter 0, TIMEOUT_IRQ=0, LAST_TO_SLOT=0, MSSPREADY/MSSPSLVERR=0, MSSPRDATA=0.
REQ-026 Reset mid-transfer abandons the transfer; no response generated; first setup after deassertion is decoded normally.

Configuration
REQ-027 Macro APB_SLOT_TIMEOUT_EN defined: counter, ERR state, TIMEOUT_IRQ and LAST_TO_SLOT per REQ-017..REQ-022.
REQ-028 Macro undefined: no counter or ERR state, ACCESS waits indefinitely for S_PREADY, TIMEOUT_IRQ and LAST_TO_SLOT tied 0, TIMEOUT_CLR ignored.

Verification
REQ-029 Write 0xDEADBEEF to MSSPADDR=0x00210, SLOT_EN=0xF, slot 2 ready after 3 waits -> S_PSEL=0100, S_PWDATA=0xDEADBEEF, MSSPREADY on 4th ACCESS cycle, SLVERR=0.
REQ-030 Read slot 1 with SLOT_EN=1101 -> S_PSEL=0000, 1-cycle ACCESS with MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0.
REQ-031 Macro defined, TO_CYCLES=16, slot 3 never ready -> ERR after 16 ACCESS cycles, SLVERR=1, TIMEOUT_IRQ=1, LAST_TO_SLOT=3; late S_PREADY[3] ignored.
REQ-032 Slot 0 ready on exactly 16th ACCESS cycle -> normal completion, TIMEOUT_IRQ stays 0; TIMEOUT_CLR pulsed together with a new timeout -> TIMEOUT_IRQ remains 1.
REQ-033 M2F_RESET_N low during ACCESS on slot 1 -> all outputs 0 immediately; after release, read of slot 0 returning 0x12345678 completes correctly.
REQ-034 Macro undefined, slot 2 held unready 300 cycles -> no response, TIMEOUT_IRQ=0; S_PREADY[2]=1 then completes transfer.

Source files
------------

// File: rtl/apb_slot_ctrl.sv
// APB3 bridge from the MSS master to four slot slaves chosen by a 2-bit address field.
// Optional per-transfer wait timeout with sticky status: define APB_SLOT_TIMEOUT_EN.
module apb_slot_ctrl #(
    parameter int SLOT_LSB  = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic                FAB_CLK,
    input  logic                M2F_RESET_N,
    input  logic                MSSPSEL,
    input  logic                MSSPENABLE,
    input  logic                MSSPWRITE,
    input  logic [19:0]         MSSPADDR,
    input  logic [31:0]         MSSPWDATA,
    output logic [31:0]         MSSPRDATA,
    output logic                MSSPREADY,
    output logic                MSSPSLVERR,
    input  logic [3:0]          SLOT_EN,
    output logic [3:0]          S_PSEL,
    output logic                S_PENABLE,
    output logic                S_PWRITE,
    output logic [SLOT_LSB-1:0] S_PADDR,
    output logic [31:0]         S_PWDATA,
    input  logic [127:0]        S_PRDATA,
    input  logic [3:0]          S_PREADY,
    input  logic [3:0]          S_PSLVERR,
    input  logic                TIMEOUT_CLR,
    output logic                TIMEOUT_IRQ,
    output logic [1:0]          LAST_TO_SLOT
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  slot;
    logic        slot_on;
    logic        slot_ready;
    logic        to_hit;
    logic [31:0] slot_rdata [4];

    assign slot       = MSSPADDR[SLOT_LSB+1:SLOT_LSB];
    assign slot_on    = SLOT_EN[slot];
    assign slot_ready = S_PREADY[slot];

    assign S_PENABLE = MSSPENABLE;
    assign S_PWRITE  = MSSPWRITE;
    assign S_PADDR   = MSSPADDR[SLOT_LSB-1:0];
    assign S_PWDATA  = MSSPWDATA;

    // Select is decoded straight from the master bus; reset and ERR both force it low.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_rdata[gi] = S_PRDATA[32*gi +: 32];
            assign S_PSEL[gi] = M2F_RESET_N && MSSPSEL && SLOT_EN[gi]
                                && (state_reg != ERR) && (slot == 2'(gi));
        end
    endgenerate

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        MSSPREADY  = 1'b0;
        MSSPSLVERR = 1'b0;
        MSSPRDATA  = '0;
        case (state_reg)
            IDLE: begin
                if (MSSPSEL && !MSSPENABLE) state_next = SETUP;
            end
            SETUP: begin
                if (MSSPENABLE)    state_next = ACCESS;
                else if (!MSSPSEL) state_next = IDLE;
            end
            ACCESS: begin
                if (!slot_on) begin
                    MSSPREADY  = 1'b1;
                    MSSPSLVERR = 1'b1;
                    state_next = IDLE;
                end else begin
                    MSSPREADY  = slot_ready;
                    MSSPSLVERR = S_PSLVERR[slot];
                    MSSPRDATA  = slot_rdata[slot];
                    // A slave answering on the threshold cycle still completes normally.
                    if (slot_ready)  state_next = IDLE;
                    else if (to_hit) state_next = ERR;
                end
            end
            ERR: begin
                MSSPREADY  = 1'b1;
                MSSPSLVERR = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef APB_SLOT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;
    logic       irq_reg;
    logic       irq_next;
    logic [1:0] last_reg;
    logic [1:0] last_next;
    logic       unused_addr;

    assign unused_addr = ^MSSPADDR[19:SLOT_LSB+2];
    assign to_hit = (state_reg == ACCESS) && slot_on && !slot_ready && (cnt_reg == TO_LAST);

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            cnt_reg  <= '0;
            irq_reg  <= 1'b0;
            last_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            irq_reg  <= irq_next;
            last_reg <= last_next;
        end
    end

    // A timeout event outranks a simultaneous clear of the sticky flag.
    always_comb begin
        cnt_next  = cnt_reg;
        irq_next  = irq_reg;
        last_next = last_reg;
        if (state_reg == IDLE && state_next == SETUP) begin
            cnt_next = '0;
        end else if (state_reg == ACCESS && slot_on && !slot_ready && !to_hit) begin
            cnt_next = cnt_reg + 8'd1;
        end
        if (to_hit) begin
            irq_next  = 1'b1;
            last_next = slot;
        end else if (TIMEOUT_CLR) begin
            irq_next = 1'b0;
        end
    end

    assign TIMEOUT_IRQ  = irq_reg;
    assign LAST_TO_SLOT = last_reg;
`else
    logic unused_bits;

    assign unused_bits  = ^{MSSPADDR[19:SLOT_LSB+2], TIMEOUT_CLR};
    assign to_hit       = 1'b0;
    assign TIMEOUT_IRQ  = 1'b0;
    assign LAST_TO_SLOT = 2'd0;
`endif

endmodule

// File: tb/tb_apb_slot_ctrl.sv
// Directed bench for apb_slot_ctrl: a driver queues expected responses, a monitor checks them.
// Latency is counted in bus cycles with MSSPSEL&MSSPENABLE high (first such cycle = 1).
module tb_apb_slot_ctrl;

    logic         fab_clk = 1'b0;
    logic         m2f_reset_n = 1'b0;
    logic         msspsel = 1'b0;
    logic         msspenable = 1'b0;
    logic         msspwrite = 1'b0;
    logic [19:0]  msspaddr = '0;
    logic [31:0]  msspwdata = '0;
    logic [31:0]  mssprdata;
    logic         msspready;
    logic         msspslverr;
    logic [3:0]   slot_en = 4'hF;
    logic [3:0]   s_psel;
    logic         s_penable;
    logic         s_pwrite;
    logic [7:0]   s_paddr;
    logic [31:0]  s_pwdata;
    logic [127:0] s_prdata = '0;
    logic [3:0]   s_pready = '0;
    logic [3:0]   s_pslverr = '0;
    logic         timeout_clr = 1'b0;
    logic         timeout_irq;
    logic [1:0]   last_to_slot;

    apb_slot_ctrl #(.SLOT_LSB(8), .TO_CYCLES(16)) dut (
        .FAB_CLK(fab_clk), .M2F_RESET_N(m2f_reset_n),
        .MSSPSEL(msspsel), .MSSPENABLE(msspenable), .MSSPWRITE(msspwrite),
        .MSSPADDR(msspaddr), .MSSPWDATA(msspwdata),
        .MSSPRDATA(mssprdata), .MSSPREADY(msspready), .MSSPSLVERR(msspslverr),
        .SLOT_EN(slot_en), .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PWRITE(s_pwrite),
        .S_PADDR(s_paddr), .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata),
        .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
        .TIMEOUT_CLR(timeout_clr), .TIMEOUT_IRQ(timeout_irq), .LAST_TO_SLOT(last_to_slot)
    );

    always #5 fab_clk = ~fab_clk;

    typedef struct {
        int          tid;
        logic [3:0]  psel;
        logic [31:0] pwdata;
        int          lat;
        logic        serr;
        logic [31:0] rdata;
        logic        irq;
        logic [1:0]  last;
    } exp_t;

    exp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;
    int mon_k = 0;
    logic [3:0]  mon_psel = '0;
    logic [31:0] mon_pwdata = '0;

    task automatic check(input int tid, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL t%0d %s: got 0x%08h expected 0x%08h", tid, nm, act, exp);
        end
    endtask

    // Monitor: captures the select/data seen by the slaves, checks each completion.
    always @(negedge fab_clk) begin
        exp_t e;
        if (!(msspsel && msspenable)) begin
            mon_k = 0;
        end else begin
            mon_k++;
            if (mon_k == 1) begin
                mon_psel   = s_psel;
                mon_pwdata = s_pwdata;
            end
        end
        if (msspready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: got MSSPREADY=1 expected 0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check(e.tid, "s_psel", 32'(mon_psel), 32'(e.psel));
                check(e.tid, "s_pwdata", mon_pwdata, e.pwdata);
                check(e.tid, "latency", 32'(mon_k), 32'(e.lat));
                check(e.tid, "slverr", 32'(msspslverr), 32'(e.serr));
                check(e.tid, "rdata", mssprdata, e.rdata);
                check(e.tid, "timeout_irq", 32'(timeout_irq), 32'(e.irq));
                check(e.tid, "last_to_slot", 32'(last_to_slot), 32'(e.last));
            end
        end
    end

    // One APB transfer. rdy_k: bus access cycle from which the target slave is ready (0 = never).
    task automatic xfer(input int tid, input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                        input logic [3:0] en, input logic [3:0] noise, input int rdy_k,
                        input logic [31:0] srdata, input logic sserr, input int clr_k, input int max_k,
                        input logic [3:0] e_psel, input int e_lat, input logic e_serr,
                        input logic [31:0] e_rdata, input logic e_irq, input logic [1:0] e_last);
        exp_t e;
        int slot;
        int k;
        bit done;
        slot = int'(addr[9:8]);
        e.tid = tid; e.psel = e_psel; e.pwdata = wdata; e.lat = e_lat;
        e.serr = e_serr; e.rdata = e_rdata; e.irq = e_irq; e.last = e_last;
        sb_q.push_back(e);
        @(posedge fab_clk); #1;
        msspsel = 1'b1; msspenable = 1'b0; msspwrite = wr; msspaddr = addr; msspwdata = wdata;
        slot_en = en; s_pready = '0; s_pslverr = '0; timeout_clr = 1'b0;
        s_prdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000} ^ {4{32'h5A5A_0F0F}};
        s_prdata[32*slot +: 32] = srdata;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge fab_clk); #1;
            k++;
            msspenable = 1'b1;
            s_pready = noise;
            s_pready[slot] = (rdy_k != 0) && (k >= rdy_k);
            s_pslverr = noise;
            s_pslverr[slot] = sserr;
            timeout_clr = (k == clr_k);
            @(negedge fab_clk);
            if (msspready) begin
                done = 1'b1;
            end else if (k >= max_k) begin
                vectors++;
                miscompares++;
                $display("FAIL t%0d no_response: got none after %0d cycles expected latency %0d", tid, k, e_lat);
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] late_rdy);
        @(posedge fab_clk); #1;
        msspsel = 1'b0; msspenable = 1'b0; s_pready = late_rdy; s_pslverr = '0; timeout_clr = 1'b0;
        repeat (n - 1) @(posedge fab_clk);
    endtask

    task automatic check_quiet(input int tid, input logic e_irq, input logic [1:0] e_last);
        check(tid, "ready_q", 32'(msspready), 32'd0);
        check(tid, "slverr_q", 32'(msspslverr), 32'd0);
        check(tid, "rdata_q", mssprdata, 32'd0);
        check(tid, "s_psel_q", 32'(s_psel), 32'd0);
        check(tid, "irq_q", 32'(timeout_irq), 32'(e_irq));
        check(tid, "last_q", 32'(last_to_slot), 32'(e_last));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge fab_clk);
        #2;
        check_quiet(0, 1'b0, 2'd0);
        @(negedge fab_clk);
        m2f_reset_n = 1'b1;
        @(negedge fab_clk);
        check_quiet(0, 1'b0, 2'd0);

        // Write slot 2, three waits, other slots' ready/err noise must not leak
        xfer(1, 1'b1, 20'h00210, 32'hDEAD_BEEF, 4'hF, 4'b1011, 5, 32'h0000_C0DE, 1'b0, 0, 40,
             4'b0100, 5, 1'b0, 32'h0000_C0DE, 1'b0, 2'd0);
        idle(2, 4'b0000);
        // Disabled slot 1: error in the first access cycle, slave ignored
        xfer(2, 1'b0, 20'h00100, 32'h0, 4'b1101, 4'b0000, 1, 32'h55AA_55AA, 1'b0, 0, 40,
             4'b0000, 2, 1'b1, 32'h0, 1'b0, 2'd0);
        // Back-to-back: zero-wait slot 3 with slave error, then slot 0
        xfer(3, 1'b0, 20'h00304, 32'h0, 4'hF, 4'b0000, 2, 32'h0BAD_F00D, 1'b1, 0, 40,
             4'b1000, 2, 1'b1, 32'h0BAD_F00D, 1'b0, 2'd0);
        xfer(4, 1'b0, 20'h00008, 32'h0, 4'hF, 4'b0000, 3, 32'h1111_2222, 1'b0, 0, 40,
             4'b0001, 3, 1'b0, 32'h1111_2222, 1'b0, 2'd0);
        // Slot 0 answers on the 16th controller access cycle (bus cycle 17)
        xfer(5, 1'b0, 20'h00000, 32'h0, 4'hF, 4'b0000, 17, 32'hA0A0_0017, 1'b0, 0, 40,
             4'b0001, 17, 1'b0, 32'hA0A0_0017, 1'b0, 2'd0);
        idle(2, 4'b0000);

`ifdef APB_SLOT_TIMEOUT_EN
        // Slot 3 never ready: 16 access cycles then one error cycle
        xfer(6, 1'b0, 20'h00300, 32'h0, 4'hF, 4'b0000, 0, 32'hFFFF_FFFF, 1'b0, 0, 40,
             4'b1000, 18, 1'b1, 32'h0, 1'b1, 2'd3);
        // Late ready from the timed-out slave
        idle(1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge fab_clk);
            check(6, "late_ready", 32'(msspready), 32'd0);
        end
        check(6, "irq_hold", 32'(timeout_irq), 32'd1);
        // Clear alone: flag drops, slot record holds
        @(posedge fab_clk); #1;
        s_pready = '0;
        timeout_clr = 1'b1;
        @(posedge fab_clk); #1;
        timeout_clr = 1'b0;
        @(negedge fab_clk);
        check(7, "irq_clr", 32'(timeout_irq), 32'd0);
        check(7, "last_hold", 32'(last_to_slot), 32'd3);
        // Clear pulsed on the cycle the timeout fires: set wins
        xfer(8, 1'b0, 20'h00104, 32'h0, 4'hF, 4'b0000, 0, 32'h0, 1'b0, 17, 40,
             4'b0010, 18, 1'b1, 32'h0, 1'b1, 2'd1);
        idle(2, 4'b0000);
`else
        // No timeout: wait 300 cycles, clear pulse has no effect
        xfer(6, 1'b1, 20'h00200, 32'h7777_0300, 4'hF, 4'b0000, 301, 32'h2222_AAAA, 1'b0, 100, 400,
             4'b0100, 301, 1'b0, 32'h2222_AAAA, 1'b0, 2'd0);
        idle(2, 4'b0000);
`endif

        // Reset in the middle of a slot 1 access while the slave turns ready
        @(posedge fab_clk); #1;
        msspsel = 1'b1; msspenable = 1'b0; msspwrite = 1'b0; msspaddr = 20'h00100; slot_en = 4'hF;
        s_prdata[63:32] = 32'hFFFF_FFFF;
        @(posedge fab_clk); #1;
        msspenable = 1'b1;
        repeat (2) @(posedge fab_clk);
        #1;
        s_pready = 4'b0010;
        s_pslverr = 4'b0010;
        m2f_reset_n = 1'b0;
        #1;
        check_quiet(9, 1'b0, 2'd0);
        @(negedge fab_clk);
        check(9, "ready_in_rst", 32'(msspready), 32'd0);
        @(posedge fab_clk); #1;
        msspsel = 1'b0; msspenable = 1'b0; s_pready = '0; s_pslverr = '0;
        m2f_reset_n = 1'b1;
        xfer(10, 1'b0, 20'h00000, 32'h0, 4'hF, 4'b0000, 2, 32'h1234_5678, 1'b0, 0, 40,
             4'b0001, 2, 1'b0, 32'h1234_5678, 1'b0, 2'd0);
        idle(3, 4'b0000);

        @(negedge fab_clk);
        check(99, "sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t expected end of test", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
